// File: rtl/dmem_pkg.sv
// Shared encodings for the data memory controller: access sizes, FSM states
// and the alignment predicate used when DMEM_ALIGN_CHECK_EN is defined.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } acc_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    // A half access must sit on an even byte, a word access on a word boundary.
    function automatic logic is_misaligned(input acc_size_e size, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        if (size == SZ_HALF && off[0]) begin
            bad = 1'b1;
        end
        if (size == SZ_WORD && off != 2'b00) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/dmem_byte_lane.sv
// Combinational byte-lane steering: builds the store byte enables and the
// merged write word, and extracts/extends the load result (little-endian).
module dmem_byte_lane
    import dmem_pkg::*;
(
    input  acc_size_e   acc_size,
    input  logic [1:0]  byte_off,
    input  logic        ld_signed,
    input  logic [31:0] st_data,
    input  logic [31:0] old_word,
    output logic [3:0]  byte_en,
    output logic [31:0] merged_word,
    output logic [31:0] ld_data
);

    logic [31:0] lane_data;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Replicate right-aligned store data onto every lane, pick the enabled lanes
    // and pull the addressed byte/half out of the stored word for loads.
    always_comb begin
        byte_en     = 4'b0000;
        lane_data   = st_data;
        ld_data     = 32'h0000_0000;
        sel_byte    = old_word[8*byte_off +: 8];
        sel_half    = byte_off[1] ? old_word[31:16] : old_word[15:0];
        merged_word = old_word;
        case (acc_size)
            SZ_BYTE: begin
                byte_en   = 4'b0001 << byte_off;
                lane_data = {4{st_data[7:0]}};
                ld_data   = {{24{ld_signed & sel_byte[7]}}, sel_byte};
            end
            SZ_HALF: begin
                byte_en   = byte_off[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{st_data[15:0]}};
                ld_data   = {{16{ld_signed & sel_half[15]}}, sel_half};
            end
            SZ_WORD: begin
                byte_en   = 4'b1111;
                lane_data = st_data;
                ld_data   = old_word;
            end
            default: begin
                byte_en   = 4'b0000;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                merged_word[8*i +: 8] = lane_data[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: single-port word array behind an IDLE/WAIT/RESP
// handshake with WAIT_CYCLES wait states and byte/half/word accesses.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (misaligned half/word accesses
// complete as errors; otherwise the low address bits are forced to zero).
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_r,
    input  logic        dmem_w,
    input  logic [31:0] data_addr,
    input  logic [31:0] w_data,
    input  logic [1:0]  acc_size,
    input  logic        ld_signed,
    output logic [31:0] dmem_data,
    output logic        dmem_ready,
    output logic        dmem_busy,
    output logic        dmem_err
);

    localparam int AW    = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AW+1:0]     addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    acc_size_e         size_q, size_d;
    logic              signed_q, signed_d;
    logic              write_q, write_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [31:0]       mem [DEPTH_WORDS];

    logic [AW+1:0]     eff_addr;
    logic [31:0]       eff_wdata;
    acc_size_e         eff_size;
    logic              eff_signed;
    logic [1:0]        eff_off;
    logic [AW-1:0]     word_idx;
    logic [31:0]       rd_word;
    logic [3:0]        byte_en;
    logic [31:0]       merged_word;
    logic [31:0]       ld_data;
    logic              req_any;
    logic              req_err;
    logic              commit;
    logic              commit_write;
    logic              mem_we;

    // While idle the live request drives the datapath so a zero-wait access can
    // complete on its accept edge; afterwards the latched copy is used.
    always_comb begin
        eff_addr   = addr_q;
        eff_wdata  = wdata_q;
        eff_size   = size_q;
        eff_signed = signed_q;
        if (state_q == IDLE) begin
            eff_addr   = data_addr[AW+1:0];
            eff_wdata  = w_data;
            eff_size   = acc_size_e'(acc_size);
            eff_signed = ld_signed;
        end
        case (eff_size)
            SZ_HALF: eff_off = {eff_addr[1], 1'b0};
            SZ_WORD: eff_off = 2'b00;
            default: eff_off = eff_addr[1:0];
        endcase
        word_idx = eff_addr[AW+1:2];
        rd_word  = mem[word_idx];
    end

    dmem_byte_lane u_lane (
        .acc_size    (eff_size),
        .byte_off    (eff_off),
        .ld_signed   (eff_signed),
        .st_data     (eff_wdata),
        .old_word    (rd_word),
        .byte_en     (byte_en),
        .merged_word (merged_word),
        .ld_data     (ld_data)
    );

    // Classify the incoming request: conflicting strobes, reserved size and
    // (optionally) misalignment all short-circuit to an error response.
    always_comb begin
        req_any = dmem_r | dmem_w;
`ifdef DMEM_ALIGN_CHECK_EN
        req_err = (dmem_r & dmem_w) | (acc_size == SZ_RSVD)
                | is_misaligned(acc_size_e'(acc_size), data_addr[1:0]);
`else
        req_err = (dmem_r & dmem_w) | (acc_size == SZ_RSVD);
`endif
    end

    // Next-state logic: accept in IDLE, count wait states, one-cycle RESP, and
    // commit the store or capture the load on the edge that enters RESP.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        signed_d     = signed_q;
        write_d      = write_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
        commit       = 1'b0;
        commit_write = write_q;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    addr_d       = data_addr[AW+1:0];
                    wdata_d      = w_data;
                    size_d       = acc_size_e'(acc_size);
                    signed_d     = ld_signed;
                    write_d      = dmem_w;
                    err_d        = req_err;
                    cnt_d        = '0;
                    commit_write = dmem_w;
                    if (req_err) begin
                        state_d = RESP;
                    end else if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        mem_we = commit & commit_write & ~rst;
        if (commit && !commit_write) begin
            rdata_d = ld_data;
        end
    end

    // Control and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            write_q  <= write_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage array; never cleared by reset, written only by a completing store.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_idx] <= merged_word;
        end
    end

    assign dmem_data  = rdata_q;
    assign dmem_ready = (state_q == RESP);
    assign dmem_busy  = (state_q != IDLE);
    assign dmem_err   = (state_q == RESP) & err_q;

endmodule
